// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: PC advance/select, imem read enable, flush and halt.
// Optional FETCH_CTRL_PERF_EN adds fetch/stall performance counters.
module fetch_ctrl #(
    parameter int PC_SRC_W = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                ihit,
    input  logic                stall,
    input  logic                halt,
    input  logic                redir_valid,
    input  logic [PC_SRC_W-1:0] redir_src,
    input  logic                redir_taken,
    output logic                imemREN,
    output logic                pcEN,
    output logic [PC_SRC_W-1:0] pc_src,
    output logic                branchmux,
    output logic                fetch_valid,
    output logic                flush,
    output logic                halted,
`ifdef FETCH_CTRL_PERF_EN
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         stall_cnt,
`endif
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                state, next_state;
    logic                  pend_v, pend_v_n;
    logic [PC_SRC_W-1:0]   pend_src, pend_src_n;
    logic                  eff_redir;

    assign state_dbg = state;

    // Not-taken branches and src 0 are not redirects.
    assign eff_redir = redir_valid &&
                       ((redir_src == PC_SRC_W'(2)) || (redir_src == PC_SRC_W'(3)) ||
                        ((redir_src == PC_SRC_W'(1)) && redir_taken));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= INIT;
            pend_v   <= 1'b0;
            pend_src <= '0;
        end else begin
            state    <= next_state;
            pend_v   <= pend_v_n;
            pend_src <= pend_src_n;
        end
    end

    always_comb begin
        next_state  = state;
        pend_v_n    = pend_v;
        pend_src_n  = pend_src;
        imemREN     = 1'b0;
        pcEN        = 1'b0;
        pc_src      = '0;
        branchmux   = 1'b0;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        halted      = 1'b0;
        case (state)
            INIT: next_state = FETCH;
            FETCH: begin
                imemREN = 1'b1;
                if (halt) begin
                    imemREN    = 1'b0;
                    flush      = 1'b1;
                    pend_v_n   = 1'b0;
                    next_state = HALTED;
                end else if (pend_v) begin
                    // Already flushed at capture; any new redirect now is wrong-path.
                    if (ihit) begin
                        pcEN      = 1'b1;
                        pc_src    = pend_src;
                        branchmux = (pend_src == PC_SRC_W'(1));
                        flush     = 1'b1;
                        pend_v_n  = 1'b0;
                    end
                end else if (eff_redir) begin
                    flush = 1'b1;
                    if (ihit) begin
                        pcEN      = 1'b1;
                        pc_src    = redir_src;
                        branchmux = (redir_src == PC_SRC_W'(1));
                    end else begin
                        pend_v_n   = 1'b1;
                        pend_src_n = redir_src;
                    end
                end else if (ihit && !stall) begin
                    pcEN        = 1'b1;
                    fetch_valid = 1'b1;
                end
            end
            HALTED: halted = 1'b1;
            default: next_state = INIT;
        endcase
    end

`ifdef FETCH_CTRL_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else if (state == FETCH) begin
            if (fetch_valid)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (!pcEN && !halt)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: per-cycle reference model plus directed literal checks.
// Define FETCH_CTRL_PERF_EN for both files to exercise the counters.
module tb_fetch_ctrl;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       ihit = 1'b0, stall = 1'b0, halt = 1'b0;
    logic       redir_valid = 1'b0, redir_taken = 1'b0;
    logic [1:0] redir_src = 2'd0;
    logic       imemREN, pcEN, branchmux, fetch_valid, flush, halted;
    logic [1:0] pc_src, state_dbg;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.PC_SRC_W(2)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
        .redir_valid(redir_valid), .redir_src(redir_src), .redir_taken(redir_taken),
        .imemREN(imemREN), .pcEN(pcEN), .pc_src(pc_src), .branchmux(branchmux),
        .fetch_valid(fetch_valid), .flush(flush), .halted(halted),
`ifdef FETCH_CTRL_PERF_EN
        .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt),
`endif
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    // Reference model: the first cycle after reset is idle, halting is sticky,
    // and at most one redirect waits for an ihit.
    logic        m_init = 1'b1;
    logic        m_halted = 1'b0;
    logic [1:0]  pend_q[$];
    logic [31:0] m_fcnt = 0, m_scnt = 0;

    function automatic logic is_redir();
        return redir_valid && (redir_src == 2'd2 || redir_src == 2'd3 ||
                               (redir_src == 2'd1 && redir_taken));
    endfunction

    // {imemREN, pcEN, pc_src[1:0], branchmux, fetch_valid, flush, halted}
    function automatic logic [7:0] model_out();
        logic [1:0] tgt;
        if (!nRST || m_init) return 8'h00;
        if (m_halted)        return 8'b0000_0001;
        if (halt)            return 8'b0000_0010;
        if (pend_q.size() > 0) begin
            tgt = pend_q[0];
            if (ihit) return {2'b11, tgt, tgt == 2'd1, 3'b010};
            return 8'b1000_0000;
        end
        if (is_redir()) begin
            tgt = redir_src;
            if (ihit) return {2'b11, tgt, tgt == 2'd1, 3'b010};
            return 8'b1000_0010;
        end
        if (ihit && !stall) return 8'b1100_0100;
        return 8'b1000_0000;
    endfunction

    always @(negedge nRST) begin
        m_init   = 1'b1;
        m_halted = 1'b0;
        pend_q.delete();
        m_fcnt   = 0;
        m_scnt   = 0;
    end

    always @(posedge CLK) begin
        logic [7:0] e;
        if (nRST) begin
            e = model_out();
            if (m_init) begin
                m_init = 1'b0;
            end else if (!m_halted) begin
                if (e[2]) m_fcnt = m_fcnt + 1;
                if (!e[6] && !halt) m_scnt = m_scnt + 1;
                if (halt) begin
                    m_halted = 1'b1;
                    pend_q.delete();
                end else if (pend_q.size() > 0) begin
                    if (ihit) void'(pend_q.pop_front());
                end else if (is_redir() && !ihit) begin
                    pend_q.push_back(redir_src);
                end
            end
        end
    end

    always @(negedge CLK) begin
        logic [7:0] got, exp;
        got = {imemREN, pcEN, pc_src, branchmux, fetch_valid, flush, halted};
        exp = model_out();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL model_cmp t=%0t got=%b expected=%b", $time, got, exp);
        end
`ifdef FETCH_CTRL_PERF_EN
        checks++;
        if (fetch_cnt !== m_fcnt || stall_cnt !== m_scnt) begin
            errors++;
            $display("FAIL perf_cmp t=%0t got=%0d/%0d expected=%0d/%0d",
                     $time, fetch_cnt, stall_cnt, m_fcnt, m_scnt);
        end
`endif
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic i, input logic s, input logic h,
                         input logic rv, input logic [1:0] rs, input logic rt);
        @(posedge CLK);
        #1;
        ihit = i; stall = s; halt = h;
        redir_valid = rv; redir_src = rs; redir_taken = rt;
        #1;
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        nRST = 1'b0;
        ihit = 0; stall = 0; halt = 0; redir_valid = 0; redir_src = 0; redir_taken = 0;
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
        #1;
        chk("init_outputs", {imemREN, pcEN, pc_src, branchmux, fetch_valid, flush, halted}, 8'h00);
    endtask

    initial begin
        // 1: INIT then four straight-line fetches
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 2'd0, 0);
            chk("t1_pcen_fv_src", {pcEN, fetch_valid, pc_src}, 4'b1100);
        end

        // 2: taken branch applies immediately; not-taken is a plain +4
        drive(1, 0, 0, 1, 2'd1, 1);
        chk("t2_taken", {pcEN, pc_src, branchmux, flush, fetch_valid}, 6'b101110);
        drive(1, 0, 0, 1, 2'd1, 0);
        chk("t2_not_taken", {pcEN, pc_src, branchmux, flush, fetch_valid}, 6'b100001);

        // 3: redirect captured during a wait; the later one is wrong-path
        drive(0, 0, 0, 1, 2'd3, 0);
        chk("t3_capture_flush", {flush, pcEN}, 2'b10);
        drive(0, 0, 0, 1, 2'd2, 0);
        chk("t3_discard_noflush", {flush, pcEN}, 2'b00);
        drive(0, 0, 0, 0, 2'd0, 0);
        drive(1, 0, 0, 0, 2'd0, 0);
        chk("t3_apply_jr", {pcEN, pc_src, branchmux, flush}, 5'b11101);
        drive(1, 0, 0, 0, 2'd0, 0);
        chk("t3_after_apply", {pcEN, pc_src, flush, fetch_valid}, 5'b10001);

        // 4: stall holds the PC while still reading
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 2'd0, 0);
            chk("t4_stall", {imemREN, pcEN, fetch_valid}, 3'b100);
        end
        drive(1, 0, 0, 0, 2'd0, 0);
        chk("t4_release", {pcEN, fetch_valid}, 2'b11);

        // 5: halt beats a simultaneous redirect, then is sticky
        drive(1, 0, 1, 1, 2'd2, 0);
        chk("t5_halt_cycle", {pcEN, flush, halted}, 3'b010);
        drive(1, 0, 0, 1, 2'd2, 0);
        chk("t5_halted", {halted, imemREN, pcEN, flush}, 4'b1000);
        drive(1, 0, 0, 0, 2'd0, 0);
        chk("t5_still_halted", halted, 1);

        // 5b: reset during a wait with a redirect pending
        do_reset();
        drive(0, 0, 0, 1, 2'd3, 0);
        drive(0, 0, 0, 0, 2'd0, 0);
        #1 nRST = 1'b0;
        #1 chk("t5_async_reset", {imemREN, pcEN, pc_src, branchmux, fetch_valid, flush, halted}, 8'h00);
        @(posedge CLK);
        #1 nRST = 1'b1;
        drive(1, 0, 0, 0, 2'd0, 0);
        chk("t5_pend_cleared", {pcEN, pc_src, flush, fetch_valid}, 5'b10001);

        // 6: five fetches and two stall cycles, then halt
        do_reset();
        repeat (5) drive(1, 0, 0, 0, 2'd0, 0);
        repeat (2) drive(1, 1, 0, 0, 2'd0, 0);
        drive(1, 0, 1, 0, 2'd0, 0);
`ifdef FETCH_CTRL_PERF_EN
        chk("t6_fetch_cnt", fetch_cnt, 5);
        chk("t6_stall_cnt", stall_cnt, 2);
`endif
        drive(1, 0, 0, 0, 2'd0, 0);
        drive(1, 0, 0, 0, 2'd0, 0);
`ifdef FETCH_CTRL_PERF_EN
        chk("t6_frozen", {fetch_cnt[15:0], stall_cnt[15:0]}, {16'd5, 16'd2});
`endif
        @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
